// File: rtl/matrix_input_collector.sv
// Collects a byte stream (m, n, then m*n row-major elements) into a zero-padded
// packed MAX_DIM x MAX_DIM matrix and holds it with mat_valid until acknowledged.
module matrix_input_collector #(
    parameter int MAX_DIM  = 5,
    parameter int ELEM_W   = 8,
    parameter int ELEM_MAX = 9
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                clear,
    input  logic                                in_valid,
    input  logic [ELEM_W-1:0]                   in_data,
    output logic                                in_ready,
    input  logic                                out_ack,
    output logic [2:0]                          mat_m,
    output logic [2:0]                          mat_n,
    output logic [MAX_DIM*MAX_DIM*ELEM_W-1:0]   matrix_out,
    output logic                                mat_valid,
    output logic                                err,
    output logic [4:0]                          elem_count
);

    localparam int MAT_W  = MAX_DIM * MAX_DIM * ELEM_W;
    localparam int BASE_W = $clog2(MAT_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_N,
        S_GET_ELEM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [2:0]          r_mat_m;
    logic [2:0]          r_mat_n;
    logic [2:0]          r_row;
    logic [2:0]          r_col;
    logic [4:0]          r_elem_count;
    logic [MAT_W-1:0]    r_matrix;

    logic                w_xfer;
    logic                w_dim_ok;
    logic                w_elem_ok;
    logic                w_col_wrap;
    logic                w_last;
    logic [4:0]          w_slot;
    logic [BASE_W-1:0]   w_base;

    assign w_xfer     = in_valid && in_ready;
    // Full-byte compare so values such as 8'h0D are rejected rather than truncated.
    assign w_dim_ok   = (in_data != '0) && (in_data <= ELEM_W'(MAX_DIM));
    assign w_elem_ok  = (in_data <= ELEM_W'(ELEM_MAX));
    assign w_col_wrap = (r_col == r_mat_n - 3'd1);
    assign w_last     = w_col_wrap && (r_row == r_mat_m - 3'd1);
    assign w_slot     = 5'(r_row) * 5'(MAX_DIM) + 5'(r_col);
    assign w_base     = BASE_W'(w_slot) * BASE_W'(ELEM_W);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_next_state = r_state;
        if (clear) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:     if (w_xfer) w_next_state = w_dim_ok ? S_GET_N : S_ERROR;
                S_GET_N:    if (w_xfer) w_next_state = w_dim_ok ? S_GET_ELEM : S_ERROR;
                S_GET_ELEM: begin
                    if (w_xfer) begin
                        if (!w_elem_ok) begin
                            w_next_state = S_ERROR;
                        end else if (w_last) begin
                            w_next_state = S_DONE;
                        end
                    end
                end
                S_DONE:     if (out_ack) w_next_state = S_IDLE;
                S_ERROR:    w_next_state = S_ERROR;
                default:    w_next_state = S_IDLE;
            endcase
        end
    end

    // Handshake and status depend on state only, so in_valid/in_data never reach an output.
    always_comb begin
        in_ready  = 1'b0;
        mat_valid = 1'b0;
        err       = 1'b0;
        case (r_state)
            S_IDLE, S_GET_N, S_GET_ELEM: in_ready  = 1'b1;
            S_DONE:                      mat_valid = 1'b1;
            S_ERROR:                     err       = 1'b1;
            default:                     in_ready  = 1'b0;
        endcase
    end

    // NOTE: the matrix is a flat register bank, not a RAM, so it is reset and
    // cleared along with the rest of the datapath.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mat_m      <= '0;
            r_mat_n      <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_elem_count <= '0;
            r_matrix     <= '0;
        end else if (clear) begin
            r_mat_m      <= '0;
            r_mat_n      <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_elem_count <= '0;
            r_matrix     <= '0;
        end else if (w_xfer) begin
            case (r_state)
                S_IDLE: begin
                    if (w_dim_ok) begin
                        r_mat_m      <= in_data[2:0];
                        r_matrix     <= '0;
                        r_elem_count <= '0;
                    end
                end
                S_GET_N: begin
                    if (w_dim_ok) begin
                        r_mat_n <= in_data[2:0];
                        r_row   <= '0;
                        r_col   <= '0;
                    end
                end
                S_GET_ELEM: begin
                    if (w_elem_ok) begin
                        r_matrix[w_base +: ELEM_W] <= in_data;
                        r_elem_count               <= r_elem_count + 5'd1;
                        if (w_col_wrap) begin
                            r_col <= '0;
                            r_row <= r_row + 3'd1;
                        end else begin
                            r_col <= r_col + 3'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mat_m      = r_mat_m;
    assign mat_n      = r_mat_n;
    assign matrix_out = r_matrix;
    assign elem_count = r_elem_count;

endmodule

// File: tb/tb_matrix_input_collector.sv
// Directed self-checking bench for matrix_input_collector: loads, dimension and
// element errors, backpressure, clear/reset aborts and reload.
module tb_matrix_input_collector;

    logic         clk = 1'b0;
    logic         reset;
    logic         clear;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_ready;
    logic         out_ack;
    logic [2:0]   mat_m;
    logic [2:0]   mat_n;
    logic [199:0] matrix_out;
    logic         mat_valid;
    logic         err;
    logic [4:0]   elem_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [199:0] exp_mat;
    logic [7:0]   seq_2x3 [8] = '{8'd2, 8'd3, 8'd1, 8'd2, 8'd3, 8'd3, 8'd4, 8'd5};

    matrix_input_collector dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_ack    (out_ack),
        .mat_m      (mat_m),
        .mat_n      (mat_n),
        .matrix_out (matrix_out),
        .mat_valid  (mat_valid),
        .err        (err),
        .elem_count (elem_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic ack();
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_ready"}, 200'(in_ready),   200'd1);
        check({tag, "_valid"}, 200'(mat_valid),  200'd0);
        check({tag, "_err"},   200'(err),        200'd0);
        check({tag, "_mat"},   matrix_out,       200'd0);
        check({tag, "_cnt"},   200'(elem_count), 200'd0);
        check({tag, "_m"},     200'(mat_m),      200'd0);
        check({tag, "_n"},     200'(mat_n),      200'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        out_ack  = 1'b0;
        #2;
        check_cleared("reset");
        #10 reset = 1'b1;

        // 2x3 load with in_valid held high for all eight bytes
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = seq_2x3[i];
            tick();
            if (i == 6) check("2x3_valid_early", 200'(mat_valid), 200'd0);
        end
        in_valid = 1'b0;
        exp_mat = '0;
        exp_mat[0*8 +: 8] = 8'd1;
        exp_mat[1*8 +: 8] = 8'd2;
        exp_mat[2*8 +: 8] = 8'd3;
        exp_mat[5*8 +: 8] = 8'd3;
        exp_mat[6*8 +: 8] = 8'd4;
        exp_mat[7*8 +: 8] = 8'd5;
        check("2x3_valid", 200'(mat_valid),  200'd1);
        check("2x3_ready", 200'(in_ready),   200'd0);
        check("2x3_mat",   matrix_out,       exp_mat);
        check("2x3_m",     200'(mat_m),      200'd2);
        check("2x3_n",     200'(mat_n),      200'd3);
        check("2x3_cnt",   200'(elem_count), 200'd6);
        tick();
        check("2x3_hold",  200'(mat_valid),  200'd1);
        ack();
        check("ack_ready", 200'(in_ready),   200'd1);
        check("ack_valid", 200'(mat_valid),  200'd0);
        check("ack_keep",  matrix_out,       exp_mat);
        check("ack_cnt",   200'(elem_count), 200'd6);

        // Dimension errors
        send(8'd0);
        check("m0_err",   200'(err),      200'd1);
        check("m0_ready", 200'(in_ready), 200'd0);
        send(8'd2);
        check("err_sticky", 200'(err), 200'd1);
        pulse_clear();
        check_cleared("clr1");
        send(8'd2);
        send(8'd6);
        check("n6_err", 200'(err), 200'd1);
        check("n6_m",   200'(mat_m), 200'd2);
        pulse_clear();
        send(8'd13);
        check("m13_err", 200'(err),   200'd1);
        check("m13_m",   200'(mat_m), 200'd0);
        pulse_clear();

        // Element out of range
        send(8'd1);
        send(8'd2);
        send(8'd4);
        check("elem_ok_err", 200'(err), 200'd0);
        send(8'd10);
        check("elem_err",   200'(err),        200'd1);
        check("elem_valid", 200'(mat_valid),  200'd0);
        check("elem_cnt",   200'(elem_count), 200'd1);
        pulse_clear();

        // 5x5 with idle gaps; garbage on in_data while in_valid is low
        send(8'd5);
        send(8'd5);
        exp_mat = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                in_data = 8'hFF;
                repeat ($urandom_range(0, 2)) tick();
                exp_mat[(r * 5 + c) * 8 +: 8] = 8'((r + c) % 10);
                send(8'((r + c) % 10));
            end
        end
        check("5x5_valid", 200'(mat_valid),  200'd1);
        check("5x5_mat",   matrix_out,       exp_mat);
        check("5x5_cnt",   200'(elem_count), 200'd25);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        repeat (3) tick();
        in_valid = 1'b0;
        check("done_ready", 200'(in_ready),   200'd0);
        check("done_err",   200'(err),        200'd0);
        check("done_cnt",   200'(elem_count), 200'd25);
        check("done_mat",   matrix_out,       exp_mat);
        ack();

        // clear after 3 elements of a 2x2 load, with a coinciding transfer
        send(8'd2);
        send(8'd2);
        send(8'd1);
        send(8'd2);
        send(8'd3);
        check("abort_cnt", 200'(elem_count), 200'd3);
        in_valid = 1'b1;
        in_data  = 8'd4;
        pulse_clear();
        in_valid = 1'b0;
        check_cleared("abort_clr");

        // Reset mid-load takes effect without a clock edge
        send(8'd2);
        send(8'd2);
        send(8'd5);
        send(8'd6);
        #2 reset = 1'b0;
        #1;
        check_cleared("abort_rst");
        #1 reset = 1'b1;
        tick();

        // Reload: completed 2x2, then 1x1 with element 7
        send(8'd2);
        send(8'd2);
        send(8'd1);
        send(8'd2);
        send(8'd3);
        send(8'd4);
        check("r2x2_valid", 200'(mat_valid), 200'd1);
        ack();
        send(8'd1);
        check("reload_zero", matrix_out,       200'd0);
        check("reload_cnt",  200'(elem_count), 200'd0);
        check("reload_m",    200'(mat_m),      200'd1);
        send(8'd1);
        send(8'd7);
        check("reload_valid", 200'(mat_valid), 200'd1);
        check("reload_mat",   matrix_out,      200'd7);
        check("reload_n",     200'(mat_n),     200'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/matrix_input_collector.md
Name: matrix_input_collector

Overview:
- Upstream feeder for the matrix arithmetic units, including the scalar multiplier.
- Accepts a byte stream over a valid/ready handshake, in the order: row count m, column count n, then m*n elements in row-major order.
- Validates dimensions and element range, then assembles the packed 5x5 matrix bus (8 bits per element, zero-padded) with m/n outputs.
- Holds the result with mat_valid asserted until downstream acknowledges it.

Parameters:
MAX_DIM, 5, maximum rows/cols; legal dimension range is 1..MAX_DIM
ELEM_W, 8, element width in bits; matrix bus width = MAX_DIM*MAX_DIM*ELEM_W
ELEM_MAX, 9, largest legal element value (unsigned)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
clear  in  1  synchronous abort; returns block to IDLE
in_valid  in  1  input byte valid
in_data  in  8  dimension or element byte
in_ready  out  1  block can accept a byte this cycle
out_ack  in  1  downstream consumed matrix (honoured only in DONE)
mat_m  out  3  accepted row count
mat_n  out  3  accepted column count
matrix_out  out  200  packed matrix; element (r,c) at bits [(r*5+c)*8 +: 8]
mat_valid  out  1  matrix complete and stable
err  out  1  sticky error flag
elem_count  out  5  elements accepted so far in the current load (0..25)

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0 except in_ready, which is 1.
- Transfer rule: a byte transfers on a rising edge when in_valid && in_ready. in_ready is a function of state only, never of in_valid.
- State IDLE (in_ready=1), on transfer:
  - in_data in 1..MAX_DIM: mat_m <= in_data[2:0]; matrix_out <= 0; elem_count <= 0; go to GET_N.
  - Otherwise: go to ERROR.
- State GET_N (in_ready=1), on transfer:
  - Legal dimension: mat_n <= in_data[2:0]; row=col=0; go to GET_ELEM.
  - Otherwise: go to ERROR.
- State GET_ELEM (in_ready=1), on transfer:
  - in_data > ELEM_MAX: go to ERROR.
  - Otherwise: write to slot (row*5+col); elem_count++.
  - col wraps at mat_n-1 to 0, and row increments.
  - When the element at (m-1, n-1) is accepted, go to DONE.
- State DONE (in_ready=0, mat_valid=1):
  - mat_valid rises on the cycle after the last-element edge; latency 1 clock.
  - out_ack=1: go to IDLE next edge; mat_valid drops.
  - matrix_out, mat_m, mat_n and elem_count are retained until the next m byte is accepted.
- State ERROR (in_ready=0, err=1, mat_valid=0): exits only via clear or reset.
- clear=1: synchronous; takes priority over every other input in every state.
  - Next state IDLE; err, mat_valid, elem_count, mat_m, mat_n and matrix_out all cleared.
  - A transfer coinciding with clear is discarded.
- out_ack outside DONE is ignored. in_valid while in_ready=0 is ignored and causes no error.
- Unused slots (row >= m or col >= n) are always 0.
- Dimension check uses the full 8-bit in_data, so a byte of 8'h0D is illegal, not truncated to 5.
- No combinational path from in_valid/in_data to any output.
- Reset asserted mid-load aborts the load immediately; the partial matrix is lost.

Test Plan:
- 2x3 load: bytes 2,3,1,2,3,3,4,5, in_valid held high → mat_valid rises 1 cycle after the 8th transfer. matrix_out bytes 0,1,2,5,6,7 = 1,2,3,3,4,5; all other bytes 0; mat_m=2, mat_n=3, elem_count=6. Then out_ack=1 → IDLE and in_ready=1 next cycle.
- Dimension errors:
  - m byte 0 → err=1, in_ready=0 next cycle.
  - After clear, m=2 then n=6 → err=1.
  - After clear, m byte 13 → err=1.
- Element range: 1x2 load with elements 4 then 10 → err=1, mat_valid stays 0, elem_count=1.
- Backpressure/idle gaps: 5x5 load of values (r+c) mod 10, with in_valid toggled randomly → all 25 slots correct; elem_count=25; extra bytes in DONE not accepted (in_ready=0).
- Abort paths:
  - clear after 3 elements of a 2x2 load → next cycle IDLE, matrix_out=0, elem_count=0, mat_m=0.
  - reset pulsed low mid-load → same result immediately, without waiting for a clock edge.
- Reload: after a completed 2x2 load is acked, start a 1x1 load with element 7 → matrix_out zeroed on the m byte; final matrix_out has byte0=7 and all other bytes 0.
